// File: rtl/tpu_pkg.sv
// Shared types and constants for the C-buffer requantisation block.
package tpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int LANES         = 4;
    localparam int ADDR_BITS_DEF = 12;
    localparam int INT8_MIN      = -128;
    localparam int INT8_MAX      = 127;

    // Clamp to [lo, hi]; the upper bound is applied last so lo > hi yields hi.
    function automatic logic [7:0] clamp_i8(input logic signed [31:0] v,
                                            input logic signed [7:0]  lo,
                                            input logic signed [7:0]  hi);
        logic signed [31:0] lo_w;
        logic signed [31:0] hi_w;
        logic signed [31:0] t;
        lo_w = 32'(lo);
        hi_w = 32'(hi);
        t    = (v < lo_w) ? lo_w : v;
        t    = (t > hi_w) ? hi_w : t;
        return t[7:0];
    endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requant datapath: bias add, Q31 multiply with rounding
// shift, output offset and int8 clamp, one register per stage.
module requant_lane
    import tpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] acc_i,
    input  logic [31:0] bias_i,
    input  logic [31:0] mult_i,
    input  logic [3:0]  shift_i,
    input  logic [31:0] offset_i,
    input  logic [7:0]  act_min_i,
    input  logic [7:0]  act_max_i,
    output logic [7:0]  res_o
);

    logic [31:0]        s_q;
    logic [31:0]        r_q;
    logic [31:0]        r_d;
    logic [31:0]        v_d;
    logic [7:0]         res_q;
    logic [7:0]         res_d;
    logic signed [63:0] s_ext;
    logic signed [63:0] m_ext;
    logic signed [63:0] prod;
    logic signed [63:0] rounded;
    logic [5:0]         sh_round;
    logic [5:0]         sh_total;

    // Multiply/round for the r stage and offset/clamp for the output stage.
    always_comb begin
        s_ext    = {{32{s_q[31]}}, s_q};
        m_ext    = {{32{mult_i[31]}}, mult_i};
        prod     = s_ext * m_ext;
        sh_round = 6'd30 + {2'b00, shift_i};
        sh_total = sh_round + 6'd1;
        rounded  = (prod + (64'sd1 <<< sh_round)) >>> sh_total;
        r_d      = rounded[31:0];
        v_d      = r_q + offset_i;
        res_d    = clamp_i8(v_d, act_min_i, act_max_i);
    end

    // Stage registers: s = acc + bias, r = rounded product, res = clamped result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q   <= '0;
            r_q   <= '0;
            res_q <= '0;
        end else begin
            s_q   <= acc_i + bias_i;
            r_q   <= r_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/c_requant.sv
// Streams C-buffer rows through LANES requant lanes and writes packed int8
// results to the O buffer, four cycles after each row address is issued.
module c_requant #(
    parameter int ADDR_BITS = tpu_pkg::ADDR_BITS_DEF,
    parameter int LANES     = tpu_pkg::LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_BITS-1:0]   num_rows,
    input  logic [32*LANES-1:0]    bias,
    input  logic [31:0]            mult,
    input  logic [3:0]             shift,
    input  logic [31:0]            out_offset,
    input  logic [7:0]             act_min,
    input  logic [7:0]             act_max,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_BITS-1:0]   C_index,
    input  logic [32*LANES-1:0]    C_data_out,
    output logic                   O_wr_en,
    output logic [ADDR_BITS-1:0]   O_index,
    output logic [8*LANES-1:0]     O_data_in
);
    import tpu_pkg::*;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   rows_q;
    logic [ADDR_BITS-1:0]   cidx_q;
    logic [32*LANES-1:0]    bias_q;
    logic [31:0]            mult_q;
    logic [3:0]             shift_q;
    logic [31:0]            offset_q;
    logic [7:0]             min_q;
    logic [7:0]             max_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   issue_v_q;
    logic                   rd_v_q;
    logic                   s_v_q;
    logic                   r_v_q;
    logic                   wr_q;
    logic [ADDR_BITS-1:0]   rd_idx_q;
    logic [ADDR_BITS-1:0]   s_idx_q;
    logic [ADDR_BITS-1:0]   r_idx_q;
    logic [ADDR_BITS-1:0]   oidx_q;
    logic [8*LANES-1:0]     odata;

    // Job control: latch config on start, issue row addresses, drain, pulse done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rows_q    <= '0;
            cidx_q    <= '0;
            bias_q    <= '0;
            mult_q    <= '0;
            shift_q   <= '0;
            offset_q  <= '0;
            min_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            issue_v_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rows_q   <= num_rows;
                        bias_q   <= bias;
                        mult_q   <= mult;
                        shift_q  <= shift;
                        offset_q <= out_offset;
                        min_q    <= act_min;
                        max_q    <= act_max;
                        busy_q   <= 1'b1;
                        cidx_q   <= '0;
                        if (num_rows != '0) begin
                            state_q   <= ST_RUN;
                            issue_v_q <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (cidx_q == rows_q - ADDR_BITS'(1)) begin
                        state_q   <= ST_DRAIN;
                        issue_v_q <= 1'b0;
                    end else begin
                        cidx_q <= cidx_q + ADDR_BITS'(1);
                    end
                end
                ST_DRAIN: begin
                    // Leave once only the final stage is still occupied: its
                    // write lands on this edge, so done follows it directly.
                    if (!rd_v_q && !s_v_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Valid/index shadow of the lane pipeline; the C-buffer read register is
    // the capture stage, so the lanes start at the bias add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_v_q   <= 1'b0;
            s_v_q    <= 1'b0;
            r_v_q    <= 1'b0;
            wr_q     <= 1'b0;
            rd_idx_q <= '0;
            s_idx_q  <= '0;
            r_idx_q  <= '0;
            oidx_q   <= '0;
        end else begin
            rd_v_q   <= issue_v_q;
            s_v_q    <= rd_v_q;
            r_v_q    <= s_v_q;
            wr_q     <= r_v_q;
            rd_idx_q <= cidx_q;
            s_idx_q  <= rd_idx_q;
            r_idx_q  <= s_idx_q;
            oidx_q   <= r_idx_q;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        requant_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .acc_i     (C_data_out[32*k +: 32]),
            .bias_i    (bias_q[32*k +: 32]),
            .mult_i    (mult_q),
            .shift_i   (shift_q),
            .offset_i  (offset_q),
            .act_min_i (min_q),
            .act_max_i (max_q),
            .res_o     (odata[8*k +: 8])
        );
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign C_index   = cidx_q;
    assign O_wr_en   = wr_q;
    assign O_index   = oidx_q;
    assign O_data_in = odata;

endmodule

// File: tb/tb_c_requant.sv
// Directed bench for c_requant with a scoreboard of expected O-buffer writes.
module tb_c_requant;
    import tpu_pkg::*;

    localparam int AB = 12;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AB-1:0] num_rows;
    logic [127:0]  bias;
    logic [31:0]   mult;
    logic [3:0]    shift;
    logic [31:0]   out_offset;
    logic [7:0]    act_min;
    logic [7:0]    act_max;
    logic          busy;
    logic          done;
    logic [AB-1:0] C_index;
    logic [127:0]  C_data_out;
    logic          O_wr_en;
    logic [AB-1:0] O_index;
    logic [31:0]   O_data_in;

    always #5 clk = ~clk;

    c_requant #(.ADDR_BITS(AB), .LANES(NL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_rows   (num_rows),
        .bias       (bias),
        .mult       (mult),
        .shift      (shift),
        .out_offset (out_offset),
        .act_min    (act_min),
        .act_max    (act_max),
        .busy       (busy),
        .done       (done),
        .C_index    (C_index),
        .C_data_out (C_data_out),
        .O_wr_en    (O_wr_en),
        .O_index    (O_index),
        .O_data_in  (O_data_in)
    );

    // C-buffer model: one-cycle registered read.
    logic [127:0] cmem [0:4095];
    always @(posedge clk) C_data_out <= cmem[C_index];

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] data;
        longint      at;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_err = 0;
    int     wr_count = 0;
    int     done_count = 0;
    longint done_cyc = 0;
    longint start_cyc = 0;
    int     cur_rows = 0;
    bit     job_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_lane(input int acc, input int b, input int m,
                                            input int sh, input int off,
                                            input int mn, input int mx);
        int     s;
        longint p;
        longint r;
        int     v;
        int     res;
        s = acc + b;
        p = longint'(s) * longint'(m);
        r = (p + (longint'(1) << (30 + sh))) >>> (31 + sh);
        v = int'(r) + off;
        if (mn > mx)      res = mx;
        else if (v < mn)  res = mn;
        else if (v > mx)  res = mx;
        else              res = v;
        return res[7:0];
    endfunction

    function automatic logic [31:0] model_row(input logic [127:0] row, input logic [127:0] b,
                                              input int m, input int sh, input int off,
                                              input int mn, input int mx);
        logic [31:0] w;
        for (int k = 0; k < NL; k++)
            w[8*k +: 8] = ref_lane(int'(row[32*k +: 32]), int'(b[32*k +: 32]), m, sh, off, mn, mx);
        return w;
    endfunction

    // Output monitor: C_index sequencing, scoreboard pops, done tracking.
    always @(negedge clk) begin
        if (job_active && cyc >= start_cyc && cyc < start_cyc + longint'(cur_rows))
            check("c_index", 32'(C_index), 32'(cyc - start_cyc));
        if (O_wr_en) begin
            wr_count++;
            check("wr_busy", 32'(busy), 32'd1);
            n_cmp++;
            assert (sbq.size() > 0) else begin
                n_err++;
                $error("FAIL wr_unexpected observed O_index=%0d expected no write", O_index);
            end
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                check("o_index", 32'(O_index), 32'(mon_e.idx));
                check("o_data", O_data_in, mon_e.data);
                check("wr_cycle", 32'(cyc - start_cyc), 32'(mon_e.at - start_cyc));
            end
        end
        if (done) begin
            done_count++;
            done_cyc = cyc;
        end
    end

    task automatic pulse_start(input int n);
        num_rows   = AB'(n);
        cur_rows   = n;
        wr_count   = 0;
        done_count = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        start_cyc  = cyc;
        job_active = 1'b1;
    endtask

    task automatic push_expected(input int n, input bit use_model, input logic [31:0] fixed,
                                 input logic [127:0] cb, input int cm, input int csh,
                                 input int coff, input int cmn, input int cmx);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = i;
            e.data = use_model ? model_row(cmem[i], cb, cm, csh, coff, cmn, cmx) : fixed;
            e.at   = start_cyc + longint'(i) + 4;
            sbq.push_back(e);
        end
    endtask

    task automatic run_job(input string tag, input int n, input int restart_at,
                           input bit use_model, input logic [31:0] fixed);
        logic [127:0] cb;
        int cm, csh, coff, cmn, cmx;
        cb   = bias;
        cm   = mult;
        csh  = int'(shift);
        coff = out_offset;
        cmn  = signed'(act_min);
        cmx  = signed'(act_max);
        pulse_start(n);
        push_expected(n, use_model, fixed, cb, cm, csh, coff, cmn, cmx);
        @(negedge clk);
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int k = 0; k < n + 20 && done_count == 0; k++) begin
            @(negedge clk);
            if (k == restart_at) begin
                start = 1'b1;
                mult  = mult ^ 32'h1234_5678;
                bias  = ~bias;
                shift = shift + 4'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        job_active = 1'b0;
        check({tag, "_done_count"}, 32'(done_count), 32'd1);
        check({tag, "_wr_count"}, 32'(wr_count), 32'(n));
        check({tag, "_done_cycle"}, 32'(done_cyc - start_cyc), (n == 0) ? 32'd1 : 32'(n + 4));
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    task automatic fill_random(input int n, input int span);
        int a[4];
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) a[k] = int'($urandom_range(0, 2 * span)) - span;
            cmem[i] = {a[3], a[2], a[1], a[0]};
        end
    endtask

    initial begin
        logic [127:0] cb;
        int cm, csh, coff, cmn, cmx;

        rst_n = 1'b0; start = 1'b0; num_rows = '0; bias = '0; mult = '0; shift = '0;
        out_offset = '0; act_min = 8'(INT8_MIN); act_max = 8'(INT8_MAX);
        for (int i = 0; i < 4096; i++) cmem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(O_wr_en), 32'd0);
        check("rst_c_index", 32'(C_index), 32'd0);
        check("rst_o_index", 32'(O_index), 32'd0);
        check("rst_o_data", O_data_in, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-row arithmetic: 100 * 0.5 rounds to 50, minus 128
        cmem[0] = {4{32'd100}};
        bias = '0; mult = 32'h4000_0000; shift = 4'd0; out_offset = 32'hFFFF_FF80;
        run_job("single", 1, -1, 1'b0, 32'hB2B2_B2B2);

        // Clamping at both int8 rails
        cmem[0] = {32'd0, 32'd5, 32'hFFFF_FC18, 32'd1000};
        mult = 32'h7FFF_FFFF; out_offset = 32'd0;
        run_job("clamp", 1, -1, 1'b0, 32'h0005_807F);

        // Streaming 16 rows, per-lane bias, nonzero shift, narrow bounds
        fill_random(16, 1000);
        for (int k = 0; k < 4; k++) bias[32*k +: 32] = int'($urandom_range(0, 1000)) - 500;
        mult = 32'h2A00_0000; shift = 4'd1; out_offset = 32'd3;
        act_min = 8'(-100); act_max = 8'd90;
        run_job("stream", 16, -1, 1'b1, 32'd0);

        // Inverted bounds resolve to act_max
        act_min = 8'd10; act_max = 8'hFB;
        run_job("inverted", 3, -1, 1'b0, 32'hFBFB_FBFB);

        // Empty job
        act_min = 8'(INT8_MIN); act_max = 8'(INT8_MAX);
        run_job("empty", 0, -1, 1'b1, 32'd0);

        // Second start mid-job with altered config is ignored
        fill_random(8, 3000);
        mult = 32'h5555_0000; shift = 4'd2; out_offset = 32'hFFFF_FFF0;
        run_job("restart", 8, 2, 1'b1, 32'd0);

        // Reset abort at row 5 of 16
        fill_random(16, 800);
        mult = 32'h3000_0000; shift = 4'd0; out_offset = 32'd0;
        cb = bias; cm = mult; csh = int'(shift); coff = out_offset;
        cmn = signed'(act_min); cmx = signed'(act_max);
        pulse_start(16);
        push_expected(16, 1'b1, 32'd0, cb, cm, csh, coff, cmn, cmx);
        for (int k = 0; k < 10 && cyc != start_cyc + 5; k++) @(negedge clk);
        check("abort_c_index", 32'(C_index), 32'd5);
        rst_n = 1'b0;
        job_active = 1'b0;
        @(posedge clk);
        #1;
        sbq.delete();
        @(negedge clk);
        check("abort_wr_en", 32'(O_wr_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_writes", 32'(wr_count), 32'd2);
        check("abort_no_done", 32'(done_count), 32'd0);

        // Maximum row count, wide operands, maximum shift
        for (int i = 0; i < 4095; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
        cmem[4095] = '1;
        bias = {$urandom, $urandom, $urandom, $urandom};
        mult = 32'h7ABC_1234; shift = 4'd15; out_offset = 32'd7;
        run_job("max_rows", 4095, -1, 1'b1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
